// File: rtl/score_keeper.sv
// Rhythm-game scoring stage: judges chart notes against played notes inside a
// timing window and keeps a BCD score/combo word for the seven-segment driver.

module score_keeper_bcd_digit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
    c_o = (raw > 5'd9);
    s_o = c_o ? 4'(raw - 5'd10) : raw[3:0];
  end
endmodule

module score_keeper_bcd_add #(
  parameter int NUM_DIGITS = 6
) (
  input  logic [NUM_DIGITS-1:0][3:0] a_i,
  input  logic [NUM_DIGITS-1:0][3:0] b_i,
  output logic [NUM_DIGITS-1:0][3:0] sum_o,
  output logic                       carry_o
);
  logic [NUM_DIGITS:0] cy;

  assign cy[0]   = 1'b0;
  assign carry_o = cy[NUM_DIGITS];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    score_keeper_bcd_digit u_dig (
      .a_i (a_i[d]),
      .b_i (b_i[d]),
      .c_i (cy[d]),
      .s_o (sum_o[d]),
      .c_o (cy[d+1])
    );
  end
endmodule

module score_keeper #(
  parameter logic [23:0] HIT_WINDOW = 24'd10_000_000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        chart_strobe_i,
  input  logic [5:0]  chart_note_i,
  input  logic        play_strobe_i,
  input  logic [5:0]  play_note_i,
  output logic [31:0] seg_data_o,
  output logic [2:0]  multiplier_o,
  output logic        hit_pulse_o,
  output logic        miss_pulse_o,
  output logic        window_open_o
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_WINDOW = 1'b1;

  logic [0:0]  state_q,  state_d;
  logic [23:0] timer_q,  timer_d;
  logic [5:0]  target_q, target_d;
  logic [23:0] score_q,  score_d;
  logic [7:0]  combo_q,  combo_d;
  logic [2:0]  mult_q,   mult_d;
  logic        hit_q,    hit_d;
  logic        miss_q,   miss_d;

  // Multiplier for this hit comes from the combo tens digit before increment.
  logic [2:0]  hit_mult;
  logic [23:0] score_addend, score_sum, score_sat;
  logic        score_cy;
  logic [7:0]  combo_sum, combo_inc;
  logic        combo_cy;
  logic [2:0]  mult_next;
  logic        is_hit;

  assign hit_mult     = (combo_q[7:4] >= 4'd3) ? 3'd4 : {1'b0, combo_q[5:4]} + 3'd1;
  assign score_addend = {16'h0, 1'b0, hit_mult, 4'h0};

  score_keeper_bcd_add #(.NUM_DIGITS(6)) u_score_add (
    .a_i     (score_q),
    .b_i     (score_addend),
    .sum_o   (score_sum),
    .carry_o (score_cy)
  );

  score_keeper_bcd_add #(.NUM_DIGITS(2)) u_combo_add (
    .a_i     (combo_q),
    .b_i     (8'h01),
    .sum_o   (combo_sum),
    .carry_o (combo_cy)
  );

  // A carry out of the top digit means the true total passed 999999 (or 99).
  assign score_sat = score_cy ? 24'h999999 : score_sum;
  assign combo_inc = combo_cy ? 8'h99 : combo_sum;
  assign mult_next = (combo_inc[7:4] >= 4'd3) ? 3'd4 : {1'b0, combo_inc[5:4]} + 3'd1;
  assign is_hit    = play_strobe_i && (play_note_i == target_q);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    target_d = target_q;
    score_d  = score_q;
    combo_d  = combo_q;
    mult_d   = mult_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    if (state_q == S_WINDOW) begin
      if (is_hit) begin
        hit_d   = 1'b1;
        score_d = score_sat;
        combo_d = combo_inc;
        mult_d  = mult_next;
        state_d = S_IDLE;
      end else if (chart_strobe_i || timer_q == 24'd1) begin
        miss_d  = 1'b1;
        combo_d = 8'h00;
        mult_d  = 3'd1;
        state_d = S_IDLE;
      end else begin
        timer_d = timer_q - 24'd1;
      end
    end

    // A new chart note always (re)opens the window after the old one is judged.
    if (chart_strobe_i) begin
      state_d  = S_WINDOW;
      timer_d  = HIT_WINDOW;
      target_d = chart_note_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      state_q  <= S_IDLE;
      timer_q  <= 24'd0;
      target_q <= 6'd0;
      score_q  <= 24'h0;
      combo_q  <= 8'h0;
      mult_q   <= 3'd1;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      mult_q   <= mult_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign seg_data_o    = {combo_q, score_q};
  assign multiplier_o  = mult_q;
  assign hit_pulse_o   = hit_q;
  assign miss_pulse_o  = miss_q;
  assign window_open_o = (state_q == S_WINDOW);
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: expected judgements are queued as stimulus
// is driven and checked by a monitor whenever a hit/miss pulse appears.

module tb_score_keeper;
  logic        clock_i = 1'b0;
  logic        reset_i, clear_i;
  logic        chart_strobe_i, play_strobe_i;
  logic [5:0]  chart_note_i, play_note_i;
  logic [31:0] seg_data_o;
  logic [2:0]  multiplier_o;
  logic        hit_pulse_o, miss_pulse_o, window_open_o;

  score_keeper #(.HIT_WINDOW(24'd4)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .clear_i        (clear_i),
    .chart_strobe_i (chart_strobe_i),
    .chart_note_i   (chart_note_i),
    .play_strobe_i  (play_strobe_i),
    .play_note_i    (play_note_i),
    .seg_data_o     (seg_data_o),
    .multiplier_o   (multiplier_o),
    .hit_pulse_o    (hit_pulse_o),
    .miss_pulse_o   (miss_pulse_o),
    .window_open_o  (window_open_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic        hit;
    logic        miss;
    logic [31:0] seg;
    logic [2:0]  mult;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   m_score = 0;
  int   m_combo = 0;

  function automatic logic [31:0] enc(input int combo, input int score);
    logic [31:0] r;
    int s, c;
    r = 32'h0;
    s = score;
    c = combo;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    for (int i = 0; i < 2; i++) begin
      r[24 + 4*i +: 4] = 4'(c % 10);
      c = c / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] mult_of(input int combo);
    return 3'(1 + ((combo / 10) > 3 ? 3 : combo / 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
  endtask

  task automatic exp_hit();
    exp_t e;
    m_score = m_score + 10 * int'(mult_of(m_combo));
    if (m_score > 999999) m_score = 999999;
    m_combo = (m_combo >= 99) ? 99 : m_combo + 1;
    e.hit = 1'b1; e.miss = 1'b0;
    e.seg = enc(m_combo, m_score);
    e.mult = mult_of(m_combo);
    sbq.push_back(e);
  endtask

  task automatic exp_miss();
    exp_t e;
    m_combo = 0;
    e.hit = 1'b0; e.miss = 1'b1;
    e.seg = enc(m_combo, m_score);
    e.mult = 3'd1;
    sbq.push_back(e);
  endtask

  // Drive one edge's worth of inputs; outputs are sampled 1 time unit after it.
  task automatic tick(input logic cs, input logic [5:0] cn, input logic ps, input logic [5:0] pn);
    chart_strobe_i = cs; chart_note_i = cn;
    play_strobe_i  = ps; play_note_i  = pn;
    @(posedge clock_i);
    #1;
    chart_strobe_i = 1'b0;
    play_strobe_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic one_hit(input logic [5:0] note);
    tick(1'b1, note, 1'b0, 6'd0);
    exp_hit();
    tick(1'b0, 6'd0, 1'b1, note);
  endtask

  task automatic one_miss(input logic [5:0] note);
    tick(1'b1, note, 1'b0, 6'd0);
    idle(3);
    exp_miss();
    tick(1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued judgement.
  always @(negedge clock_i) begin
    if (hit_pulse_o === 1'b1 || miss_pulse_o === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pulse observed hit=%b miss=%b expected none", hit_pulse_o, miss_pulse_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_hit",  {31'h0, hit_pulse_o},  {31'h0, e.hit});
        chk("sb_miss", {31'h0, miss_pulse_o}, {31'h0, e.miss});
        chk("sb_seg",  seg_data_o, e.seg);
        chk("sb_mult", {29'h0, multiplier_o}, {29'h0, e.mult});
      end
    end
  end

  initial begin
    reset_i = 1'b1; clear_i = 1'b0;
    chart_strobe_i = 1'b0; chart_note_i = 6'd0;
    play_strobe_i = 1'b0;  play_note_i = 6'd0;

    // Reset held with strobes toggling
    for (int i = 0; i < 3; i++) begin
      tick(i[0] == 1'b0, 6'd12, i[0] == 1'b0, 6'd12);
      chk("rst_seg",  seg_data_o, 32'h0);
      chk("rst_mult", {29'h0, multiplier_o}, 32'd1);
      chk("rst_pulses", {30'h0, hit_pulse_o, miss_pulse_o}, 32'd0);
      chk("rst_win", {31'h0, window_open_o}, 32'd0);
    end
    reset_i = 1'b0;
    idle(1);

    // Basic hit two edges after the chart strobe
    tick(1'b1, 6'd12, 1'b0, 6'd0);
    chk("hit_win_open", {31'h0, window_open_o}, 32'd1);
    idle(1);
    exp_hit();
    tick(1'b0, 6'd0, 1'b1, 6'd12);
    chk("hit_pulse", {31'h0, hit_pulse_o}, 32'd1);
    chk("hit_seg", seg_data_o, 32'h01000010);
    chk("hit_win_closed", {31'h0, window_open_o}, 32'd0);
    idle(1);
    chk("hit_pulse_one_cycle", {31'h0, hit_pulse_o}, 32'd0);

    // Wrong note is ignored; miss lands exactly HIT_WINDOW edges later
    tick(1'b1, 6'd5, 1'b0, 6'd0);
    tick(1'b0, 6'd0, 1'b1, 6'd7);
    chk("wrong_no_pulse", {30'h0, hit_pulse_o, miss_pulse_o}, 32'd0);
    chk("wrong_win_open", {31'h0, window_open_o}, 32'd1);
    idle(2);
    chk("pre_miss_no_pulse", {30'h0, hit_pulse_o, miss_pulse_o}, 32'd0);
    exp_miss();
    idle(1);
    chk("miss_pulse", {31'h0, miss_pulse_o}, 32'd1);
    chk("miss_seg", seg_data_o, 32'h00000010);
    chk("miss_win_closed", {31'h0, window_open_o}, 32'd0);

    // Clear, then 12 hits crossing the first multiplier step, then a miss
    clear_i = 1'b1; idle(1); clear_i = 1'b0;
    m_score = 0; m_combo = 0;
    chk("clear_seg", seg_data_o, 32'h0);
    for (int i = 0; i < 12; i++) one_hit(6'(i + 20));
    chk("hits12_seg", seg_data_o, 32'h12000140);
    chk("hits12_mult", {29'h0, multiplier_o}, 32'd2);
    one_miss(6'd33);
    chk("after_miss_seg", seg_data_o, 32'h00000140);
    chk("after_miss_mult", {29'h0, multiplier_o}, 32'd1);

    // Second chart note truncates the first window
    tick(1'b1, 6'd3, 1'b0, 6'd0);
    idle(1);
    exp_miss();
    tick(1'b1, 6'd4, 1'b0, 6'd0);
    chk("trunc_miss", {31'h0, miss_pulse_o}, 32'd1);
    chk("trunc_win_open", {31'h0, window_open_o}, 32'd1);
    exp_hit();
    tick(1'b0, 6'd0, 1'b1, 6'd4);
    chk("trunc_hit", {31'h0, hit_pulse_o}, 32'd1);
    chk("trunc_hit_seg", seg_data_o, 32'h01000150);

    // Mid-window reset drops the window silently
    tick(1'b1, 6'd9, 1'b0, 6'd0);
    reset_i = 1'b1; idle(1); reset_i = 1'b0;
    m_score = 0; m_combo = 0;
    chk("midrst_seg", seg_data_o, 32'h0);
    chk("midrst_win", {31'h0, window_open_o}, 32'd0);
    idle(6);
    chk("midrst_quiet", {30'h0, hit_pulse_o, miss_pulse_o}, 32'd0);

    // Mid-window clear with score 000050
    for (int i = 0; i < 5; i++) one_hit(6'(i + 40));
    chk("pre_clear_seg", seg_data_o, 32'h05000050);
    tick(1'b1, 6'd9, 1'b0, 6'd0);
    clear_i = 1'b1; idle(1); clear_i = 1'b0;
    m_score = 0; m_combo = 0;
    chk("midclr_seg", seg_data_o, 32'h0);
    chk("midclr_win", {31'h0, window_open_o}, 32'd0);
    idle(6);
    chk("midclr_quiet", {30'h0, hit_pulse_o, miss_pulse_o}, 32'd0);

    // Long hit run: combo saturates at 99, multiplier tops out at 4
    for (int i = 0; i < 120; i++) one_hit(6'(i % 64));
    chk("long_seg", seg_data_o, 32'h99004200);
    chk("long_mult", {29'h0, multiplier_o}, 32'd4);

    idle(2);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side scoring stage that feeds the 8-digit seven-segment display driver.
- Takes chart-note arrivals from the note scheduler and played-note events from the FFT pitch link.
- Judges each chart note as a hit or a miss within a timing window.
- Tracks combo count, combo multiplier and a BCD score, and outputs a display-ready 32-bit word.

Parameters:
- HIT_WINDOW, 24'd10_000_000, window length in clock cycles during which a played note can hit a chart note (100 ms at 100 MHz). Must be ≥ 1.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous game-restart pulse; zeroes score and combo, closes any window
- chart_strobe  in  1  one-cycle pulse: a chart note reached the strike line
- chart_note  in  6  note index accompanying chart_strobe
- play_strobe  in  1  one-cycle pulse: a new played note was detected
- play_note  in  6  note index accompanying play_strobe
- seg_data  out  32  {combo BCD[7:0], score BCD[23:0]} for the display driver
- multiplier  out  3  current multiplier, 1..4
- hit_pulse  out  1  one-cycle pulse on a judged hit
- miss_pulse  out  1  one-cycle pulse on a judged miss
- window_open  out  1  high while a hit window is active

Behaviour:
- Priority: reset > clear > judging logic.
- reset and clear both set: state IDLE, seg_data=0, multiplier=1, hit_pulse=0, miss_pulse=0, window_open=0, timer=0.
- State IDLE:
  - chart_strobe at edge k latches chart_note into target, loads timer=HIT_WINDOW, and moves to WINDOW.
  - play_strobe is ignored.
- State WINDOW: at each edge, evaluate in this order.
  - Hit: play_strobe=1 and play_note==target. Register hit_pulse, update combo and score, leave WINDOW.
  - Miss: otherwise, if timer==1. Register miss_pulse, set combo=0, leave WINDOW. Score is unchanged.
  - Otherwise decrement timer.
  - If play_note!=target, the strobe is ignored: no penalty, combo kept.
  - Net effect: play strobes sampled at edges k+1 through k+HIT_WINDOW can hit. A miss registers at edge k+HIT_WINDOW.
- chart_strobe arriving while in WINDOW, at the same edge:
  - The old note is judged first: hit if a matching play_strobe is present, otherwise miss (window truncated).
  - A new window then opens for the new chart_note with timer=HIT_WINDOW. State stays WINDOW.
- Latency:
  - hit_pulse and miss_pulse are high for exactly the cycle after the judging edge.
  - Score, combo and multiplier reflect the judgement in that same cycle.
- Arithmetic on a hit:
  - multiplier = 1 + min(combo_before/10, 3), using the combo value before increment.
  - Points = 10 × multiplier, added as BCD into the tens digit with ripple carry across 6 digits.
  - Score saturates at 999999 and never wraps.
  - Combo is a 2-digit BCD count, incremented and saturating at 99.
  - The multiplier output is recomputed from the new combo and is registered.
- window_open = (state==WINDOW).
- Reset or clear mid-window: the window is dropped silently, with no hit or miss pulse.

Test Plan:
- Reset held 3 cycles, strobes toggling -> seg_data=32'h00000000, multiplier=1, no pulses, window_open=0.
- HIT_WINDOW=4: chart_strobe note 12, play_strobe note 12 two edges later -> hit_pulse 1 cycle, seg_data=32'h01000010, window_open falls.
- HIT_WINDOW=4: chart_strobe note 5, play note 7 at edge +1, no note 5 -> no hit; miss_pulse exactly 4 edges after the chart edge; combo 00; score unchanged.
- 12 consecutive hits -> hits 1–10 score 10 each, hits 11–12 score 20 each; seg_data=32'h12000140, multiplier=2. Then a miss -> seg_data=32'h00000140, multiplier=1.
- chart_strobe note 3 then chart_strobe note 4 two edges later with no play -> miss_pulse for note 3 in the cycle after the second strobe; window stays open; play note 4 next edge -> hit.
- Mid-window reset, and separately mid-window clear with prior score 000050 -> no pulses afterward, seg_data=0, window_open=0. Long run of 120 hits -> combo holds at 99, multiplier=4.
